// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} state_e;

  localparam int CSUM_W = 8;
  localparam int LEN_W  = CSUM_W + 1;
  // A length byte of zero stands for a full 256-byte frame.
  localparam logic [LEN_W-1:0] LEN_ZERO_MEANS_256 = LEN_W'(256);

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte stream in and memory write port out of the loader.
interface instr_mem_loader_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();

  logic [DW-1:0] S_DATA;
  logic          S_VALID;
  logic          S_READY;
  logic          WE;
  logic [AW-1:0] WA;
  logic [DW-1:0] WD;

  modport master (output S_DATA, S_VALID, input S_READY, WE, WA, WD);
  modport slave  (input S_DATA, S_VALID, output S_READY, WE, WA, WD);

endinterface

// File: rtl/instr_mem_loader_timeout_counter.sv
// Mid-frame watchdog: a down-counter loaded with TIMEOUT that fires on its terminal count.
module loader_timeout_counter #(
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic increment,
  output logic expired
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CW'(TIMEOUT);
    end else if (increment && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Fires on the idle cycle that would take the count from 1 to 0.
  assign expired = increment && !clear && (cnt_q == CW'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= CW'(TIMEOUT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Frame loader: length, payload, checksum into instruction memory; releases CPU on a good frame.
// state | meaning
// IDLE  | waiting for START, stream not accepted
// LEN   | waiting for the length byte
// DATA  | writing payload bytes to memory
// CSUM  | waiting for the checksum byte
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int            AW        = 8,
  parameter int            DW        = 8,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            TIMEOUT   = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  instr_mem_loader_if.slave bus,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              CPU_HOLD
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d, wa_q, wa_d;
  logic [DW-1:0]     wd_q, wd_d;
  logic [CSUM_W-1:0] sum_q, sum_d, data_csum, csum_total;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              we_q, we_d, done_q, done_d, err_q, err_d, hold_q, hold_d;
  logic              busy, xfer, tmo_clear, tmo_inc, tmo_expired;

  assign busy       = (state_q != IDLE);
  assign xfer       = busy && bus.S_VALID;
  assign data_csum  = CSUM_W'(bus.S_DATA);
  assign csum_total = sum_q + data_csum;

  loader_timeout_counter #(.TIMEOUT(TIMEOUT), .CW(TMO_W)) u_tmo (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (tmo_clear),
    .increment (tmo_inc),
    .expired   (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    rem_d     = rem_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    done_d    = done_q;
    err_d     = err_q;
    hold_d    = hold_q;
    tmo_clear = 1'b0;
    tmo_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_clear = 1'b1;
        if (START) begin
          state_d = LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          sum_d   = '0;
          hold_d  = 1'b1;
        end
      end
      LEN: begin
        if (xfer) begin
          rem_d   = (bus.S_DATA == '0) ? LEN_ZERO_MEANS_256 : LEN_W'(bus.S_DATA);
          sum_d   = data_csum;
          addr_d  = BASE_ADDR;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          we_d   = 1'b1;
          wa_d   = addr_q;
          wd_d   = bus.S_DATA;
          addr_d = addr_q + 1'b1;
          sum_d  = sum_q + data_csum;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          if (csum_total == '0) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (busy) begin
      tmo_clear = xfer;
      tmo_inc   = !xfer;
      if (tmo_expired) begin
        state_d = IDLE;
        err_d   = 1'b1;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.S_READY = busy;
  assign bus.WE      = we_q;
  assign bus.WA      = wa_q;
  assign bus.WD      = wd_q;
  assign BUSY        = busy;
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign CPU_HOLD    = hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: frame-level reference model compared every cycle, plus fixed frames.
module tb_instr_mem_loader;

  localparam logic [7:0] BASE = 8'hF0;
  localparam int         TMO  = 1023;

  logic CLK = 1'b0;
  logic RST, START;
  logic BUSY, DONE, ERR, CPU_HOLD;

  instr_mem_loader_if #(.AW(8), .DW(8)) bus ();

  instr_mem_loader #(.AW(8), .DW(8), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .bus      (bus),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .CPU_HOLD (CPU_HOLD)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  bit rnd_start = 1'b0;
  logic [7:0]  frame_q[$];
  logic [15:0] wr_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: tracks position within the frame (0 = length byte,
  // 1..L = payload, L+1 = checksum) and the run of idle cycles.
  bit         m_busy, m_done, m_err, m_hold, m_we;
  int         m_pos, m_len, m_sum, m_idle;
  logic [7:0] m_wa, m_wd;

  always @(posedge CLK) begin
    if (RST) begin
      m_busy = 0; m_done = 0; m_err = 0; m_hold = 1; m_we = 0;
      m_pos = 0; m_len = 0; m_sum = 0; m_idle = 0; m_wa = 0; m_wd = 0;
    end else begin
      m_we = 0;
      if (!m_busy) begin
        if (START) begin
          m_busy = 1; m_pos = 0; m_idle = 0; m_done = 0; m_err = 0; m_hold = 1;
        end
      end else if (bus.S_VALID) begin
        m_idle = 0;
        if (m_pos == 0) begin
          m_len = (bus.S_DATA == 0) ? 256 : int'(bus.S_DATA);
          m_sum = int'(bus.S_DATA);
          m_pos = 1;
        end else if (m_pos <= m_len) begin
          m_we  = 1;
          m_wa  = 8'((int'(BASE) + m_pos - 1) % 256);
          m_wd  = bus.S_DATA;
          m_sum = (m_sum + int'(bus.S_DATA)) % 256;
          m_pos++;
        end else begin
          if ((m_sum + int'(bus.S_DATA)) % 256 == 0) begin
            m_done = 1; m_hold = 0;
          end else begin
            m_err = 1;
          end
          m_busy = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_err = 1; m_busy = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("cycle", {bus.S_READY, BUSY, bus.WE, bus.WA, bus.WD, DONE, ERR, CPU_HOLD},
            {m_busy, m_busy, m_we, m_wa, m_wd, m_done, m_err, m_hold});
      if (bus.WE) wr_log.push_back({bus.WA, bus.WD});
    end
  end

  task automatic idle_cycle();
    @(negedge CLK);
    bus.S_VALID = 1'b0;
    bus.S_DATA  = 8'($urandom);
    START       = 1'b0;
  endtask

  task automatic do_start(input bit with_valid, input logic [7:0] b);
    @(negedge CLK);
    START       = 1'b1;
    bus.S_VALID = with_valid;
    bus.S_DATA  = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge CLK);
      bus.S_VALID = 1'b0;
      bus.S_DATA  = 8'($urandom);
      START       = rnd_start && ($urandom_range(0, 5) == 0);
    end
    @(negedge CLK);
    bus.S_VALID = 1'b1;
    bus.S_DATA  = b;
    START       = rnd_start && ($urandom_range(0, 5) == 0);
    n = 0;
    while (!bus.S_READY) begin
      if (n == 4) begin
        n_checks++;
        $display("FAIL ready_wait: S_READY got 0 for 4 cycles, expected 1");
        break;
      end
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic build_frame(input int len, input bit good);
    int n, sum;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(len % 256));
    n   = (len % 256 == 0) ? 256 : len;
    sum = len % 256;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      sum += int'(b);
    end
    b = 8'((256 - sum % 256) % 256);
    if (!good) b = b + 8'($urandom_range(1, 255));
    frame_q.push_back(b);
  endtask

  task automatic send_frame(input int max_gap, input int long_idx);
    for (int i = 0; i < frame_q.size(); i++)
      send_byte(frame_q[i], (i == long_idx) ? TMO - 1 : $urandom_range(0, max_gap));
    idle_cycle();
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; bus.S_VALID = 1'b0; bus.S_DATA = 8'h00;
    repeat (2) @(negedge CLK);
    cmp_en = 1'b1;
    check("rst_ready", bus.S_READY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_we", bus.WE, 0);
    check("rst_wa", bus.WA, 0);
    check("rst_wd", bus.WD, 0);
    check("rst_done_err", {DONE, ERR}, 2'b00);
    check("rst_hold", CPU_HOLD, 1);
    RST = 1'b0;

    // Good frame 03,11,22,33,97
    wr_log.delete();
    frame_q = {8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    do_start(0, 8'h00);
    send_frame(0, -1);
    check("good_nwr", wr_log.size(), 3);
    check("good_wr0", wr_log[0], 16'hF011);
    check("good_wr1", wr_log[1], 16'hF122);
    check("good_wr2", wr_log[2], 16'hF233);
    check("good_busy", BUSY, 0);
    check("good_status", {DONE, ERR, CPU_HOLD}, 3'b100);
    check("model_good", {m_done, m_err, m_hold}, 3'b100);

    // Same frame with a bad checksum
    wr_log.delete();
    frame_q = {8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    do_start(0, 8'h00);
    send_frame(0, -1);
    check("bad_nwr", wr_log.size(), 3);
    check("bad_wr2", wr_log[2], 16'hF233);
    check("bad_status", {DONE, ERR, CPU_HOLD}, 3'b011);
    check("model_bad", {m_done, m_err, m_hold}, 3'b011);

    // START together with S_VALID after ERR, stray START pulses mid-frame
    build_frame(6, 1);
    do_start(1, frame_q[0]);
    idle_cycle();
    check("start_clr_err", {BUSY, ERR, CPU_HOLD}, 3'b101);
    rnd_start = 1'b1;
    send_frame(1, -1);
    rnd_start = 1'b0;
    check("restart_status", {DONE, ERR, CPU_HOLD}, 3'b100);

    // L=0 means 256 bytes; addresses wrap past FF
    wr_log.delete();
    build_frame(256, 1);
    do_start(0, 8'h00);
    send_frame(0, -1);
    check("wrap_nwr", wr_log.size(), 256);
    check("wrap_first", wr_log[0][15:8], 8'hF0);
    check("wrap_ff", wr_log[15][15:8], 8'hFF);
    check("wrap_00", wr_log[16][15:8], 8'h00);
    check("wrap_last", wr_log[255][15:8], 8'hEF);
    check("wrap_status", {DONE, ERR, CPU_HOLD}, 3'b100);

    // Gaps below the timeout, including one of TMO-1 idle cycles
    build_frame(8, 1);
    do_start(0, 8'h00);
    send_frame(3, 4);
    check("stall_status", {DONE, ERR, CPU_HOLD}, 3'b100);

    // Stop after two payload bytes
    build_frame(5, 1);
    do_start(0, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(frame_q[i], 0);
    repeat (TMO) idle_cycle();
    check("tmo_pre", BUSY, 1);
    idle_cycle();
    check("tmo_abort", {BUSY, bus.S_READY, DONE, ERR, CPU_HOLD}, 5'b00011);

    // Randomized frames with idle noise and stray START pulses
    for (int f = 0; f < 20; f++) begin
      bit good;
      int len;
      good = ($urandom_range(0, 3) != 0);
      len  = $urandom_range(1, 40);
      build_frame(len, good);
      repeat ($urandom_range(0, 3)) begin
        @(negedge CLK);
        bus.S_VALID = 1'($urandom);
        bus.S_DATA  = 8'($urandom);
        START       = 1'b0;
      end
      rnd_start = 1'($urandom);
      do_start(1'($urandom), frame_q[0]);
      send_frame(2, -1);
      rnd_start = 1'b0;
      check("frame_status", {DONE, ERR, CPU_HOLD}, good ? 3'b100 : 3'b011);
    end

    // Reset one cycle after the second payload transfer
    build_frame(5, 1);
    do_start(0, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(frame_q[i], 0);
    @(negedge CLK);
    check("pre_rst_we", {bus.WE, bus.WA, bus.WD}, {1'b1, 8'hF1, frame_q[2]});
    RST = 1'b1;
    bus.S_VALID = 1'b1;
    bus.S_DATA  = frame_q[3];
    @(negedge CLK);
    check("mid_rst", {bus.WE, BUSY, bus.S_READY, DONE, ERR, CPU_HOLD, bus.WA, bus.WD},
          {6'b000001, 16'h0000});
    RST = 1'b0;
    bus.S_VALID = 1'b0;
    build_frame(4, 1);
    do_start(0, 8'h00);
    send_frame(0, -1);
    check("post_rst_status", {DONE, ERR, CPU_HOLD}, 3'b100);

    repeat (2) idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Program loader and write-side counterpart to the instruction memory's read port.
- Accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake.
- Writes each payload byte into instruction memory through a single-cycle write strobe.
- Holds the processor core in reset until a frame has loaded and verified cleanly.

Parameters:
- AW, 8, instruction memory address width.
- DW, 8, instruction/data byte width.
- BASE_ADDR, 8'h00, first memory address written by each frame.
- TIMEOUT, 1023, idle cycles tolerated mid-frame before abort (counter width 10 bits).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request to begin receiving a frame.
- S_DATA  in  DW  stream byte.
- S_VALID  in  1  stream byte valid.
- S_READY  out  1  loader accepts byte; transfer occurs when S_VALID && S_READY on a rising edge.
- WE  out  1  memory write enable, one cycle per payload byte.
- WA  out  AW  memory write address.
- WD  out  DW  memory write data.
- BUSY  out  1  frame reception in progress.
- DONE  out  1  last frame loaded with a good checksum; sticky.
- ERR  out  1  last frame failed on checksum or timeout; sticky.
- CPU_HOLD  out  1  keep processor core in reset.

Behaviour:
- Reset and clocking: one clock (CLK); reset RST is synchronous and active-high.
- Reset values: state=IDLE, S_READY=0, WE=0, WA=0, WD=0, BUSY=0, DONE=0, ERR=0, CPU_HOLD=1.
- Reset mid-frame: same values on the next edge. Any pending WE is dropped. Bytes already written are not rolled back.
- States:
  - IDLE: S_READY=0, BUSY=0. START -> LEN; clears DONE, ERR, checksum accumulator, timeout counter; sets CPU_HOLD=1.
  - LEN: S_READY=1. On transfer, L := S_DATA (0 encodes 256), sum := S_DATA, addr := BASE_ADDR -> DATA.
  - DATA: S_READY=1.
    - Each transfer registers WE=1, WA=addr, WD=S_DATA, visible the cycle after the transfer for exactly one cycle.
    - Per transfer: addr := addr+1 mod 2^AW (wraps 255->0 silently), sum := sum+S_DATA mod 256, remaining--.
    - Transfer of the L-th byte -> CSUM.
  - CSUM: S_READY=1. On transfer:
    - If (sum+S_DATA) mod 256 == 0: DONE=1, CPU_HOLD=0 -> IDLE.
    - Otherwise: ERR=1, CPU_HOLD stays 1 -> IDLE.
- BUSY=1 in LEN, DATA, CSUM.
- Back-to-back bytes: S_VALID held high gives one transfer per cycle; WE may be high on consecutive cycles.
- Timeout: in LEN/DATA/CSUM the counter increments on every cycle without a transfer and clears on a transfer. Reaching TIMEOUT -> ERR=1, IDLE, CPU_HOLD stays 1.
- START while BUSY is ignored. START in IDLE after DONE or ERR begins a new frame and re-asserts CPU_HOLD.
- START and S_VALID in the same IDLE cycle: no byte is accepted that cycle (S_READY=0). The length byte is taken from the next cycle onward.
- S_DATA is sampled only on a transfer; its value while S_VALID=0 is don't-care.
- DONE and ERR are never high together.
- CPU_HOLD deasserts only via a good checksum.

Decomposition:
- Shared package instr_loader_pkg:
  - state enum {IDLE, LEN, DATA, CSUM}.
  - LEN_ZERO_MEANS_256 constant.
  - Checksum width constant.
- Sub-module loader_timeout_counter (clear/increment/expired) for the watchdog.
- Top-level FSM, address counter and checksum remain in instr_mem_loader.

Test Plan:
- Good frame: reset, START, stream 03,11,22,33,97 back-to-back -> WE pulses at WA=00/01/02 with WD=11/22/33; DONE=1, ERR=0, CPU_HOLD=0; BUSY low the cycle after the checksum byte.
- Bad checksum: same frame with checksum 98 -> the three writes still occur; ERR=1, DONE=0, CPU_HOLD=1.
- Wrap and L=0: BASE_ADDR=8'hF0, length byte 00, 256 payload bytes with the matching checksum -> WA runs F0..FF then 00..EF; DONE=1.
- Stall and timeout:
  - S_VALID toggled with gaps <TIMEOUT -> frame completes correctly.
  - Stop after 2 payload bytes for TIMEOUT cycles -> ERR=1, state IDLE, S_READY=0.
- Reset mid-DATA: assert RST one cycle after the 2nd payload transfer -> WE=0 next edge; all outputs at reset values; CPU_HOLD=1.
- START while BUSY mid-frame has no effect; START after ERR followed by a good frame -> ERR clears at START, DONE=1 at end.
